// File: rtl/aq_lsu_port_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : aq_lsu_port_arb_if
// Desc     : Requester-side and shared-port handshake bundle for aq_lsu_port_arb
// Revision : 1.0
// ============================================================================
interface aq_lsu_port_arb_if #(
    parameter int NUM = 4,
    parameter int DW  = 64
);
    logic [NUM-1:0]    req_vld;
    logic [NUM-1:0]    req_last;
    logic [NUM*DW-1:0] req_data;
    logic [NUM-1:0]    req_rdy;
    logic              port_vld;
    logic              port_last;
    logic [DW-1:0]     port_data;
    logic [NUM-1:0]    port_src;
    logic              port_rdy;
    logic              flush;
    logic              busy;

    modport slave (
        input  req_vld, req_last, req_data, port_rdy, flush,
        output req_rdy, port_vld, port_last, port_data, port_src, busy
    );

    modport master (
        output req_vld, req_last, req_data, port_rdy, flush,
        input  req_rdy, port_vld, port_last, port_data, port_src, busy
    );
endinterface
`default_nettype wire

// File: rtl/aq_lsu_port_arb.sv
`default_nettype none
// ============================================================================
// Module   : aq_lsu_port_arb
// Desc     : Least-recently-granted arbiter sharing one LSU port among NUM
//            requesters, with burst locking. Define AQ_PORT_ARB_PIPE_EN for a
//            one-entry registered output stage.
// Revision : 1.0
// ============================================================================
module aq_lsu_port_arb #(
    parameter int NUM = 4,
    parameter int DW  = 64
) (
    input  logic            clk,
    input  logic            rst_b,
    aq_lsu_port_arb_if.slave bus
);
    typedef enum logic [0:0] {IDLE = 1'b0, LOCK = 1'b1} state_t;

    state_t          r_state, w_state_nxt;
    logic [NUM-1:0]  r_own, w_own_nxt;
    logic [NUM-1:0]  r_prio [NUM];
    logic [NUM-1:0]  w_win, w_sel;
    logic            w_beat_vld, w_beat_last, w_take, w_acc;
    logic [DW-1:0]   w_beat_data;

    // r_prio[i][j] set means requester j beats requester i
    generate
        for (genvar gi = 0; gi < NUM; gi++) begin : g_win
            assign w_win[gi] = bus.req_vld[gi] & ~|(bus.req_vld & r_prio[gi]);
        end
    endgenerate

    assign w_sel = (r_state == LOCK) ? r_own : w_win;

    always_comb begin
        w_beat_last = 1'b0;
        w_beat_data = '0;
        for (int i = 0; i < NUM; i++) begin
            if (w_sel[i]) begin
                w_beat_last = w_beat_last | bus.req_last[i];
                w_beat_data = w_beat_data | bus.req_data[i*DW +: DW];
            end
        end
    end

    assign w_beat_vld = ~bus.flush & |(bus.req_vld & w_sel);

`ifdef AQ_PORT_ARB_PIPE_EN
    logic            r_pvld, r_plast;
    logic [DW-1:0]   r_pdata;
    logic [NUM-1:0]  r_psrc;

    assign w_take = ~r_pvld | bus.port_rdy;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_pvld  <= 1'b0;
            r_plast <= 1'b0;
            r_pdata <= '0;
            r_psrc  <= '0;
        end else if (bus.flush) begin
            r_pvld  <= 1'b0;
            r_psrc  <= '0;
        end else if (w_take) begin
            r_pvld  <= w_beat_vld;
            r_plast <= w_beat_last;
            r_pdata <= w_beat_data;
            r_psrc  <= w_beat_vld ? w_sel : '0;
        end
    end

    assign bus.port_vld  = r_pvld;
    assign bus.port_last = r_plast;
    assign bus.port_data = r_pdata;
    assign bus.port_src  = r_psrc;
`else
    assign w_take        = bus.port_rdy;
    assign bus.port_vld  = w_beat_vld;
    assign bus.port_last = w_beat_last;
    assign bus.port_data = w_beat_data;
    assign bus.port_src  = w_sel;
`endif

    assign w_acc       = w_beat_vld & w_take;
    assign bus.req_rdy = {NUM{w_acc}} & w_sel;
    assign bus.busy    = (r_state == LOCK);

    always_comb begin
        w_state_nxt = r_state;
        w_own_nxt   = r_own;
        if (bus.flush) begin
            w_state_nxt = IDLE;
            w_own_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: if (w_acc && !w_beat_last) begin
                    w_state_nxt = LOCK;
                    w_own_nxt   = w_sel;
                end
                LOCK: if (w_acc && w_beat_last) begin
                    w_state_nxt = IDLE;
                    w_own_nxt   = '0;
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_own_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= IDLE;
            r_own   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_own   <= w_own_nxt;
        end
    end

    // Completed owner drops to lowest priority; everyone else now beats it
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < NUM; i++)
                for (int j = 0; j < NUM; j++)
                    r_prio[i][j] <= (j < i);
        end else if (w_acc && w_beat_last) begin
            for (int i = 0; i < NUM; i++) begin
                if (w_sel[i]) r_prio[i] <= ~w_sel;
                else          r_prio[i] <= r_prio[i] & ~w_sel;
            end
        end
    end
endmodule
`default_nettype wire
